// File: rtl/set_time_ctrl_if.sv
// Button inputs and increment-pulse outputs between the board and the set-time controller.
// The master drives the buttons; the slave (the controller) drives the pulses.
interface set_time_ctrl_if;
  logic tick_hr;
  logic tick_min;
  logic set_alarm;
  logic clk_inc_hr;
  logic clk_inc_min;
  logic alm_inc_hr;
  logic alm_inc_min;
  logic sec_clr;
  logic busy;

  modport master (
    output tick_hr, tick_min, set_alarm,
    input  clk_inc_hr, clk_inc_min, alm_inc_hr, alm_inc_min, sec_clr, busy
  );

  modport slave (
    input  tick_hr, tick_min, set_alarm,
    output clk_inc_hr, clk_inc_min, alm_inc_hr, alm_inc_min, sec_clr, busy
  );
endinterface

// File: rtl/set_time_ctrl.sv
// Button auto-repeat scheduler: synchronizes hour/minute buttons and the alarm switch,
// grants one button at a time and emits increment pulses to the clock or alarm counters.
module set_time_ctrl #(
  parameter int FIRST_DLY = 50_000_000,
  parameter int RPT_DLY   = 10_000_000,
  parameter int CNT_W     = 27
) (
  input  logic          clk_100MHz,
  input  logic          reset,
  set_time_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, FIRST, REPEAT} state_t;

  localparam logic [CNT_W-1:0] FIRST_LOAD = CNT_W'(FIRST_DLY - 1);
  localparam logic [CNT_W-1:0] RPT_LOAD   = CNT_W'(RPT_DLY - 1);

  // Bit order {alm, min, hr} for raw and synchronized inputs
  logic [2:0] raw_in;
  logic [2:0] sync_out;

  assign raw_in = {bus.set_alarm, bus.tick_min, bus.tick_hr};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sync
      logic s1_reg;
      logic s2_reg;
      always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
          s1_reg <= 1'b0;
          s2_reg <= 1'b0;
        end else begin
          s1_reg <= raw_in[gi];
          s2_reg <= s1_reg;
        end
      end
      assign sync_out[gi] = s2_reg;
    end
  endgenerate

  logic s_hr, s_min, s_alm;
  assign s_hr  = sync_out[0];
  assign s_min = sync_out[1];
  assign s_alm = sync_out[2];

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             g_reg, g_next;   // 0 = HR, 1 = MIN
  logic             t_reg, t_next;   // 0 = CLK, 1 = ALM
  logic [3:0]       inc_reg, inc_next;  // {alm_min, alm_hr, clk_min, clk_hr}
  logic             sec_clr_reg, sec_clr_next;
  logic             busy_reg, busy_next;

  logic             fire;
  logic             held;
  logic [1:0]       sel;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    g_next     = g_reg;
    t_next     = t_reg;
    fire       = 1'b0;
    held       = g_reg ? s_min : s_hr;

    case (state_reg)
      IDLE: begin
        if (s_hr || s_min) begin
          g_next     = !s_hr;
          t_next     = s_alm;
          fire       = 1'b1;
          cnt_next   = FIRST_LOAD;
          state_next = FIRST;
        end
      end
      FIRST, REPEAT: begin
        // Release takes priority over an expiry in the same cycle
        if (!held) begin
          state_next = IDLE;
        end else if (cnt_reg == '0) begin
          fire       = 1'b1;
          cnt_next   = RPT_LOAD;
          state_next = REPEAT;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    sel          = {t_next, g_next};
    inc_next     = fire ? (4'b0001 << sel) : 4'b0000;
    sec_clr_next = fire && (sel == 2'b01);
    busy_next    = (state_next != IDLE);
  end

  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      g_reg       <= 1'b0;
      t_reg       <= 1'b0;
      inc_reg     <= 4'b0000;
      sec_clr_reg <= 1'b0;
      busy_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      g_reg       <= g_next;
      t_reg       <= t_next;
      inc_reg     <= inc_next;
      sec_clr_reg <= sec_clr_next;
      busy_reg    <= busy_next;
    end
  end

  assign bus.clk_inc_hr  = inc_reg[0];
  assign bus.clk_inc_min = inc_reg[1];
  assign bus.alm_inc_hr  = inc_reg[2];
  assign bus.alm_inc_min = inc_reg[3];
  assign bus.sec_clr     = sec_clr_reg;
  assign bus.busy        = busy_reg;

endmodule

// File: tb/tb_set_time_ctrl.sv
// Scoreboard bench for set_time_ctrl with short delays; expected pulses are queued by
// the stimulus and matched by a monitor that samples on the falling clock edge.
module tb_set_time_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  set_time_ctrl_if bus();

  set_time_ctrl #(
    .FIRST_DLY(8),
    .RPT_DLY  (4),
    .CNT_W    (4)
  ) dut (
    .clk_100MHz(clk),
    .reset     (reset),
    .bus       (bus)
  );

  // Pulse vector bit order {sec_clr, alm_inc_min, alm_inc_hr, clk_inc_min, clk_inc_hr}
  localparam logic [4:0] P_CLK_HR  = 5'b00001;
  localparam logic [4:0] P_CLK_MIN = 5'b10010;
  localparam logic [4:0] P_ALM_HR  = 5'b00100;
  localparam logic [4:0] P_ALM_MIN = 5'b01000;

  typedef struct {
    int         cyc;
    logic [4:0] pv;
  } exp_t;

  exp_t exp_q[$];
  int   cyc_cnt = 0;
  int   base = 0;
  int   errors = 0;
  int   checks = 0;
  bit   mon_en = 1'b0;

  // Edge index of the next rising edge, as seen from the falling edge
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  always @(negedge clk) begin
    logic [4:0] pv;
    exp_t       e;
    pv = {bus.sec_clr, bus.alm_inc_min, bus.alm_inc_hr, bus.clk_inc_min, bus.clk_inc_hr};
    if (mon_en && pv != 5'b0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse cycle=%0d got=%b required=none", cyc_cnt - base, pv);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc_cnt || e.pv != pv) begin
          errors++;
          $display("FAIL pulse got cycle=%0d vec=%b required cycle=%0d vec=%b",
                   cyc_cnt - base, pv, e.cyc - base, e.pv);
        end else begin
          $display("pulse cycle=%0d vec=%b", cyc_cnt - base, pv);
        end
      end
    end
  end

  task automatic begin_test(input string name);
    @(negedge clk);
    base = cyc_cnt;
    $display("test %s", name);
  endtask

  task automatic expect_pulse(input int c, input logic [4:0] pv);
    exp_t e;
    e.cyc = base + c;
    e.pv  = pv;
    exp_q.push_back(e);
  endtask

  task automatic check_val(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0d required=%0d", name, cyc_cnt - base, got, req);
    end else begin
      $display("check %s cycle=%0d value=%0d", name, cyc_cnt - base, got);
    end
  endtask

  task automatic end_test(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing got=%0d pending required=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Applies inputs shortly after the falling edge so they are stable before the next rising edge
  task automatic drive(input logic hr, input logic mn, input logic alm, input logic rst_n);
    #1;
    bus.tick_hr   = hr;
    bus.tick_min  = mn;
    bus.set_alarm = alm;
    reset         = rst_n;
  endtask

  function automatic int out_word();
    return int'({bus.sec_clr, bus.alm_inc_min, bus.alm_inc_hr,
                 bus.clk_inc_min, bus.clk_inc_hr, bus.busy});
  endfunction

  initial begin
    bus.tick_hr   = 1'b0;
    bus.tick_min  = 1'b0;
    bus.set_alarm = 1'b0;
    repeat (3) @(negedge clk);
    check_val("reset_outputs", out_word(), 0);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    check_val("idle_busy", int'(bus.busy), 0);
    mon_en = 1'b1;

    // Single press on minutes, clock target
    begin_test("single_press");
    for (int k = 0; k < 7; k++) expect_pulse((k == 0) ? 3 : 7 + 4 * k, P_CLK_MIN);
    for (int c = 0; c < 40; c++) begin
      if (c == 32) check_val("t1_busy_hold", int'(bus.busy), 1);
      if (c == 33) check_val("t1_busy_fall", int'(bus.busy), 0);
      drive(1'b0, c < 30, 1'b0, 1'b1);
      @(negedge clk);
    end
    end_test("t1");

    // Alarm routing with a short hour press
    begin_test("alarm_routing");
    expect_pulse(3, P_ALM_HR);
    for (int c = 0; c < 14; c++) begin
      if (c == 3) check_val("t2_busy", int'(bus.busy), 1);
      drive(c < 3, 1'b0, 1'b1, 1'b1);
      @(negedge clk);
    end
    end_test("t2");

    // Simultaneous press: hour wins, minutes follow after one idle cycle
    begin_test("simultaneous");
    expect_pulse(3, P_CLK_HR);
    expect_pulse(11, P_CLK_HR);
    expect_pulse(15, P_CLK_HR);
    expect_pulse(19, P_CLK_HR);
    expect_pulse(24, P_CLK_MIN);
    for (int c = 0; c < 36; c++) begin
      if (c == 22) check_val("t3_busy_hr", int'(bus.busy), 1);
      if (c == 23) check_val("t3_idle_gap", int'(bus.busy), 0);
      if (c == 24) check_val("t3_busy_min", int'(bus.busy), 1);
      drive(c < 20, c < 26, 1'b0, 1'b1);
      @(negedge clk);
    end
    end_test("t3");

    // Mode switch mid-burst stays on clock; the following press goes to alarm
    begin_test("mode_change");
    expect_pulse(3, P_CLK_MIN);
    expect_pulse(11, P_CLK_MIN);
    expect_pulse(15, P_CLK_MIN);
    expect_pulse(19, P_CLK_MIN);
    expect_pulse(33, P_ALM_MIN);
    for (int c = 0; c < 46; c++) begin
      if (c == 23) check_val("t4_release_busy", int'(bus.busy), 0);
      drive(1'b0, (c < 20) || (c >= 30 && c < 35), c >= 12, 1'b1);
      @(negedge clk);
    end
    end_test("t4");

    // Asynchronous reset in the middle of an hour burst
    begin_test("reset_mid_burst");
    expect_pulse(3, P_CLK_HR);
    expect_pulse(11, P_CLK_HR);
    expect_pulse(18, P_CLK_HR);
    expect_pulse(26, P_CLK_HR);
    for (int c = 0; c < 38; c++) begin
      if (c == 14) check_val("t5_outputs_in_reset", out_word(), 0);
      if (c == 17) check_val("t5_busy_before_refill", int'(bus.busy), 0);
      if (c == 29) check_val("t5_busy_hold", int'(bus.busy), 1);
      if (c == 30) check_val("t5_busy_fall", int'(bus.busy), 0);
      drive(c < 27, 1'b0, 1'b0, !(c == 13 || c == 14));
      @(negedge clk);
    end
    end_test("t5");

    // Release observed in the same cycle as the first counter expiry
    begin_test("release_expiry");
    expect_pulse(3, P_CLK_MIN);
    for (int c = 0; c < 20; c++) begin
      if (c == 10) check_val("t6_busy_hold", int'(bus.busy), 1);
      if (c == 11) check_val("t6_busy_fall", int'(bus.busy), 0);
      drive(1'b0, c < 8, 1'b0, 1'b1);
      @(negedge clk);
    end
    end_test("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
